apb_bus: RTL and testbench



---
 rtl/apb_bus.sv | 92 +++++++++
 tb/tb_apb_bus.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus.sv
// apb_bus: zero-wait-state APB slave holding four 32-bit configuration registers
// for the downstream codec/noise datapath.
//
// Ports:
//   clk            - system clock, rising-edge active
//   rst            - asynchronous active-low reset; clears every output
//   PADDR          - APB byte address (decoded on [3:2], upper bits must be 0)
//   PENABLE        - APB access-phase indicator
//   PSEL           - APB slave select
//   PWDATA         - APB write data
//   PWRITE         - 1 = write, 0 = read
//   PRDATA         - read data, captured at the end of the read setup phase
//   CTRL           - control register      (offset 0x0)
//   DATA_IN        - data input register   (offset 0x4)
//   CODEWORD_WIDTH - codeword width reg    (offset 0x8)
//   NOISE          - noise register        (offset 0xC)
//   start          - one-cycle pulse following each committed CTRL write
module apb_bus #(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [AMBA_WORD-1:0]       CTRL,
  output logic [AMBA_WORD-1:0]       DATA_IN,
  output logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
  output logic [AMBA_WORD-1:0]       NOISE,
  output logic                       start
);

  // Byte-lane bits are ignored; DATA_WIDTH does not shape any register.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], (DATA_WIDTH != 0)};

  logic                 addr_hit;
  logic                 wr_access;
  logic                 rd_setup;
  logic [AMBA_WORD-1:0] rd_sel;

  assign addr_hit  = (PADDR[AMBA_ADDR_WIDTH-1:4] == '0);
  // Write data is committed only in the access phase.
  assign wr_access = PSEL & PENABLE & PWRITE & addr_hit;
  // Read data is captured on the edge ending the setup phase, so it is
  // stable for the whole access phase.
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;

  always_comb begin
    rd_sel = '0;
    if (addr_hit) begin
      unique case (PADDR[3:2])
        2'd0: rd_sel = CTRL;
        2'd1: rd_sel = DATA_IN;
        2'd2: rd_sel = CODEWORD_WIDTH;
        2'd3: rd_sel = NOISE;
        default: rd_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PRDATA         <= '0;
      CTRL           <= '0;
      DATA_IN        <= '0;
      CODEWORD_WIDTH <= '0;
      NOISE          <= '0;
      start          <= 1'b0;
    end else begin
      start <= wr_access && (PADDR[3:2] == 2'd0);
      if (wr_access) begin
        unique case (PADDR[3:2])
          2'd0: CTRL           <= PWDATA;
          2'd1: DATA_IN        <= PWDATA;
          2'd2: CODEWORD_WIDTH <= PWDATA;
          2'd3: NOISE          <= PWDATA;
          default: ;
        endcase
      end
      if (rd_setup) begin
        PRDATA <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_apb_bus.sv
// Directed testbench for apb_bus. Bus inputs change on falling clock edges and
// outputs are sampled on falling edges, away from the active rising edge.
module tb_apb_bus;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic          PENABLE;
  logic          PSEL;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic [DW-1:0] PRDATA;
  logic [DW-1:0] CTRL;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] CODEWORD_WIDTH;
  logic [DW-1:0] NOISE;
  logic          start;

  int n_cmp = 0;
  int n_err = 0;

  apb_bus #(
    .AMBA_WORD      (DW),
    .AMBA_ADDR_WIDTH(AW),
    .DATA_WIDTH     (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PADDR         (PADDR),
    .PENABLE       (PENABLE),
    .PSEL          (PSEL),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PRDATA        (PRDATA),
    .CTRL          (CTRL),
    .DATA_IN       (DATA_IN),
    .CODEWORD_WIDTH(CODEWORD_WIDTH),
    .NOISE         (NOISE),
    .start         (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [DW-1:0] c, input logic [DW-1:0] d,
                            input logic [DW-1:0] w, input logic [DW-1:0] n);
    check({tag, ".CTRL"}, CTRL, c);
    check({tag, ".DATA_IN"}, DATA_IN, d);
    check({tag, ".CODEWORD_WIDTH"}, CODEWORD_WIDTH, w);
    check({tag, ".NOISE"}, NOISE, n);
  endtask

  task automatic bus_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
  endtask

  // Called at a falling edge; returns at the falling edge just after the
  // committing (access-phase) rising edge, with the bus idle.
  task automatic apb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = addr;
    PWDATA  = data;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  // Called at a falling edge; samples PRDATA during the access phase.
  task automatic apb_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    data    = PRDATA;
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          start_seen;

    // Reset held from time zero with random bus activity.
    rst = 1'b0;
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PSEL    = 1'($urandom_range(0, 1));
      PENABLE = 1'($urandom_range(0, 1));
      PWRITE  = 1'($urandom_range(0, 1));
      PADDR   = AW'($urandom_range(0, 15));
      PWDATA  = $urandom;
    end
    #1;
    check_regs("rst_hold", '0, '0, '0, '0);
    check("rst_hold.PRDATA", PRDATA, '0);
    check("rst_hold.start", {31'd0, start}, '0);
    @(negedge clk);
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_regs("rst_rel", '0, '0, '0, '0);
    check("rst_rel.PRDATA", PRDATA, '0);
    check("rst_rel.start", {31'd0, start}, '0);

    // Writes: CTRL first, start pulses once then drops.
    apb_write(20'h0, 32'h1);
    check("wr_ctrl.start", {31'd0, start}, 32'd1);
    check("wr_ctrl.CTRL", CTRL, 32'h1);
    apb_write(20'h4, 32'h7);
    check("wr_data.start", {31'd0, start}, 32'd0);
    check("wr_data.DATA_IN", DATA_IN, 32'h7);
    apb_write(20'h8, 32'h8);
    check("wr_cw.start", {31'd0, start}, 32'd0);
    apb_write(20'hC, 32'h3);
    check("wr_noise.start", {31'd0, start}, 32'd0);
    check_regs("wr_all", 32'h1, 32'h7, 32'h8, 32'h3);

    // Access-phase commit: register must not change on the setup edge.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h8; PWDATA = 32'h00A5_5A00;
    @(negedge clk);
    check("wr_setup_edge.CODEWORD_WIDTH", CODEWORD_WIDTH, 32'h8);
    PENABLE = 1'b1;
    @(negedge clk);
    bus_idle();
    check("wr_access_edge.CODEWORD_WIDTH", CODEWORD_WIDTH, 32'h00A5_5A00);
    apb_write(20'h8, 32'h8);

    // Read-back.
    apb_read(20'h0, rd); check("rd_0x0", rd, 32'h1);
    apb_read(20'h4, rd); check("rd_0x4", rd, 32'h7);
    apb_read(20'h8, rd); check("rd_0x8", rd, 32'h8);
    apb_read(20'hC, rd); check("rd_0xC", rd, 32'h3);
    check("rd_hold.PRDATA", PRDATA, 32'h3);
    check("rd.start", {31'd0, start}, 32'd0);
    check_regs("rd", 32'h1, 32'h7, 32'h8, 32'h3);

    // Unmapped address and byte-offset aliasing.
    apb_write(20'h10, 32'hDEAD_BEEF);
    check("unmap_wr.start", {31'd0, start}, 32'd0);
    check_regs("unmap_wr", 32'h1, 32'h7, 32'h8, 32'h3);
    apb_read(20'h10, rd); check("unmap_rd", rd, 32'h0);
    apb_read(20'h8_0000, rd); check("unmap_hi_rd", rd, 32'h0);
    apb_read(20'h5, rd); check("rd_0x5", rd, 32'h7);

    // Setup phase alone must not write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'h55;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    check("setup_only.DATA_IN", DATA_IN, 32'h7);
    // PENABLE without PSEL is ignored.
    PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'h66;
    @(negedge clk);
    bus_idle();
    check("nosel.DATA_IN", DATA_IN, 32'h7);

    // Back-to-back CTRL writes: two separate pulses; PRDATA untouched by writes.
    apb_write(20'h0, 32'h2);
    check("b2b1.start", {31'd0, start}, 32'd1);
    apb_write(20'h0, 32'h1);
    check("b2b2.start", {31'd0, start}, 32'd1);
    check("b2b.CTRL", CTRL, 32'h1);
    check("wr_keeps.PRDATA", PRDATA, 32'h7);
    @(negedge clk);
    check("b2b_end.start", {31'd0, start}, 32'd0);

    // Asynchronous reset between clock edges clears everything at once.
    #2;
    rst     = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 20'h0;
    PWDATA  = $urandom;
    #1;
    check_regs("async_rst", '0, '0, '0, '0);
    check("async_rst.PRDATA", PRDATA, '0);
    @(negedge clk);
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    check("async_rel.start", {31'd0, start}, 32'd0);

    // Reset during the setup phase of a DATA_IN write aborts it.
    apb_write(20'h4, 32'h3);
    check("pre_mid.DATA_IN", DATA_IN, 32'h3);
    start_seen = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'h9;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst.DATA_IN", DATA_IN, 32'h0);
    @(negedge clk);
    PENABLE = 1'b1;
    start_seen |= start;
    @(negedge clk);
    bus_idle();
    start_seen |= start;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start_seen |= start;
    end
    check("mid_rst_after.DATA_IN", DATA_IN, 32'h0);
    check("mid_rst.start_seen", {31'd0, start_seen}, 32'd0);

    // Transfers resume normally.
    apb_write(20'hC, 32'h5);
    apb_read(20'hC, rd); check("resume_rd", rd, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
